// File: rtl/rram_pkg.sv
// rram_pkg: shared definitions for the RRAM command sequencer.
//   - Command opcodes carried on IO[3:0] during a CLE strobe.
//   - Sequencer state encoding.
//   - verify_expect(): expected sense value after a program pulse.
package rram_pkg;

  localparam logic [3:0] OpForm    = 4'b0111;
  localparam logic [3:0] OpSet     = 4'b0101;
  localparam logic [3:0] OpReset   = 4'b0100;
  localparam logic [3:0] OpRead    = 4'b0010;
  localparam logic [3:0] OpConfirm = 4'b0110;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StPulse,
    StGap,
    StVerify,
    StDone
  } state_e;

  // Opcodes that may open a command from idle.
  function automatic logic is_start_op(logic [3:0] op);
    return (op == OpForm) || (op == OpSet) || (op == OpReset) || (op == OpRead);
  endfunction

  // FORM and SET leave the cell conducting (1); RESET leaves it off (0).
  function automatic logic verify_expect(logic [3:0] op);
    return (op != OpReset);
  endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// rram_pulse_timer: down-counter that times the program pulse window.
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   load_i    start a new window (overrides any window in progress)
//   length_i  window length in cycles; 0 is treated as 1
//   busy_o    a window is in progress
//   done_o    last cycle of the window
// After load_i on edge E, busy_o is high for exactly max(length_i,1) cycles and
// done_o marks the final one, so a consumer leaving on done_o at the next edge
// sees a window of exactly that length.
module rram_pulse_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] length_i,
  output logic       busy_o,
  output logic       done_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= (length_i == 8'd0) ? 8'd1 : length_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign busy_o = (cnt_q != 8'd0);
  assign done_o = (cnt_q == 8'd1);

endmodule

// File: rtl/rram_cmd_seq.sv
// rram_cmd_seq: NAND-style command/address front end sequencing RRAM
// FORM / SET / RESET (program pulse + optional verify-retry) and READ.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   CE           chip enable, active-low; high aborts any operation
//   CLE/ALE/WE   command latch, address latch, write strobe (rising WE edge)
//   IO           opcode on [3:0] (CLE) or address chunk (ALE), MSB chunk first
//   rram_data    cell sense result
//   pulse_len    program pulse length in cycles (0 treated as 1)
//   RB           ready(1)/busy(0)
//   rram_ce      array enable
//   rram_we      program pulse
//   rram_re      sense strobe
//   dout_block   latched block address (top BLK_W bits of the shift register)
//   dout_row     latched row address
//   dout_column  latched column address (LSBs)
//   op_pass      sticky pass result of the last operation
//   op_fail      sticky fail result of the last operation
//
// Build option: define RRAM_VERIFY_EN to compile in the verify/re-pulse loop
// for FORM/SET/RESET. Without it, programming ends after the gap cycle with
// op_pass=1 and no sense strobe; READ behaves identically in both builds.
module rram_cmd_seq
  import rram_pkg::*;
#(
  parameter int unsigned IO_W      = 4,
  parameter int unsigned BLK_W     = 4,
  parameter int unsigned ROW_W     = 32,
  parameter int unsigned COL_W     = 32,
  parameter int unsigned MAX_RETRY = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             CLE,
  input  logic             ALE,
  input  logic             WE,
  input  logic [IO_W-1:0]  IO,
  input  logic             rram_data,
  input  logic [7:0]       pulse_len,
  output logic             RB,
  output logic             rram_ce,
  output logic             rram_we,
  output logic             rram_re,
  output logic [BLK_W-1:0] dout_block,
  output logic [ROW_W-1:0] dout_row,
  output logic [COL_W-1:0] dout_column,
  output logic             op_pass,
  output logic             op_fail
);

  localparam int unsigned AddrW = BLK_W + ROW_W + COL_W;

  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
    $error("rram_cmd_seq: MAX_RETRY must be in 1..15");
  end
  if (IO_W < 4) begin : g_bad_io_w
    $error("rram_cmd_seq: IO_W must be at least 4");
  end

  state_e           state_q;
  logic [3:0]       op_q;
  logic [AddrW-1:0] addr_sr_q;
  logic             we_q;
  logic             arm_q;
  logic             rb_q;
  logic             ce_q;
  logic             rwe_q;
  logic             rre_q;
  logic             pass_q;
  logic             fail_q;
`ifdef RRAM_VERIFY_EN
  logic [3:0]       retry_q;
`endif

  logic       strobe;
  logic       cmd_strobe;
  logic       addr_strobe;
  logic [3:0] opcode;
  logic       confirm_pulse;
  logic       retry_pulse;
  logic       timer_load;
  logic       timer_busy;
  logic       timer_done;

  // arm_q masks the first edge after reset release so a WE held high through
  // reset is not mistaken for a fresh strobe.
  assign strobe      = arm_q & WE & ~we_q & ~CE;
  assign cmd_strobe  = strobe & CLE & ~ALE;
  assign addr_strobe = strobe & ALE & ~CLE;
  assign opcode      = IO[3:0];

  assign confirm_pulse = (state_q == StCmd) && cmd_strobe && (opcode == OpConfirm) &&
                         (op_q != OpRead);

`ifdef RRAM_VERIFY_EN
  assign retry_pulse = !CE && (state_q == StVerify) && (op_q != OpRead) &&
                       (rram_data != verify_expect(op_q)) &&
                       (32'(retry_q) < MAX_RETRY);
`else
  assign retry_pulse = 1'b0;
`endif

  assign timer_load = confirm_pulse | retry_pulse;

  rram_pulse_timer u_pulse_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (timer_load),
    .length_i (pulse_len),
    .busy_o   (timer_busy),
    .done_o   (timer_done)
  );

  // Address shift register; contents survive across operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_sr_q <= '0;
    end else if (addr_strobe && (state_q == StCmd)) begin
      addr_sr_q <= {addr_sr_q[AddrW-IO_W-1:0], IO};
    end
  end

  assign dout_block  = addr_sr_q[AddrW-1 -: BLK_W];
  assign dout_row    = addr_sr_q[COL_W +: ROW_W];
  assign dout_column = addr_sr_q[COL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      we_q    <= 1'b0;
      arm_q   <= 1'b0;
      rb_q    <= 1'b1;
      ce_q    <= 1'b0;
      rwe_q   <= 1'b0;
      rre_q   <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef RRAM_VERIFY_EN
      retry_q <= 4'd0;
`endif
    end else begin
      we_q  <= WE;
      arm_q <= 1'b1;
      if (CE) begin
        // Abort: RB low means the array was being driven.
        state_q <= StIdle;
        rb_q    <= 1'b1;
        ce_q    <= 1'b0;
        rwe_q   <= 1'b0;
        rre_q   <= 1'b0;
        if (!rb_q) begin
          fail_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_strobe && is_start_op(opcode)) begin
              op_q    <= opcode;
              state_q <= StCmd;
            end
          end
          StCmd: begin
            if (cmd_strobe) begin
              if (opcode == OpConfirm) begin
                rb_q   <= 1'b0;
                ce_q   <= 1'b1;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
`ifdef RRAM_VERIFY_EN
                retry_q <= 4'd0;
`endif
                if (op_q == OpRead) begin
                  rre_q   <= 1'b1;
                  state_q <= StVerify;
                end else begin
                  rwe_q   <= 1'b1;
                  state_q <= StPulse;
                end
              end else begin
                state_q <= StIdle;
              end
            end
          end
          StPulse: begin
            // Leaving on !timer_busy as well keeps the FSM from stalling if the
            // timer was ever idle here.
            if (timer_done || !timer_busy) begin
              rwe_q   <= 1'b0;
              state_q <= StGap;
            end
          end
          StGap: begin
`ifdef RRAM_VERIFY_EN
            rre_q   <= 1'b1;
            state_q <= StVerify;
`else
            pass_q  <= 1'b1;
            state_q <= StDone;
`endif
          end
          StVerify: begin
            rre_q <= 1'b0;
            if (op_q == OpRead) begin
              pass_q  <= rram_data;
              fail_q  <= 1'b0;
              state_q <= StDone;
            end else begin
`ifdef RRAM_VERIFY_EN
              if (rram_data == verify_expect(op_q)) begin
                pass_q  <= 1'b1;
                state_q <= StDone;
              end else if (retry_pulse) begin
                retry_q <= retry_q + 4'd1;
                rwe_q   <= 1'b1;
                state_q <= StPulse;
              end else begin
                fail_q  <= 1'b1;
                state_q <= StDone;
              end
`else
              state_q <= StDone;
`endif
            end
          end
          StDone: begin
            rb_q    <= 1'b1;
            ce_q    <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign RB      = rb_q;
  assign rram_ce = ce_q;
  assign rram_we = rwe_q;
  assign rram_re = rre_q;
  assign op_pass = pass_q;
  assign op_fail = fail_q;

endmodule

// File: tb/tb_rram_cmd_seq.sv
// tb_rram_cmd_seq: scoreboard bench for rram_cmd_seq. Directed stimulus pushes
// the expected outcome of each array operation; a monitor pops and compares on
// every RB rising edge, using pulse/sense counts it gathers while RB is low.
module tb_rram_cmd_seq;

  localparam int unsigned IO_W  = 4;
  localparam int unsigned BLK_W = 4;
  localparam int unsigned ROW_W = 8;
  localparam int unsigned COL_W = 8;
  localparam int unsigned MAXR  = 2;

`ifdef RRAM_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  localparam logic [3:0] C_FORM    = 4'b0111;
  localparam logic [3:0] C_SET     = 4'b0101;
  localparam logic [3:0] C_RESET   = 4'b0100;
  localparam logic [3:0] C_READ    = 4'b0010;
  localparam logic [3:0] C_CONFIRM = 4'b0110;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             CE = 1'b0;
  logic             CLE = 1'b0;
  logic             ALE = 1'b0;
  logic             WE = 1'b0;
  logic [IO_W-1:0]  IO = '0;
  logic             rram_data = 1'b0;
  logic [7:0]       pulse_len = 8'd3;
  logic             RB;
  logic             rram_ce;
  logic             rram_we;
  logic             rram_re;
  logic [BLK_W-1:0] dout_block;
  logic [ROW_W-1:0] dout_row;
  logic [COL_W-1:0] dout_column;
  logic             op_pass;
  logic             op_fail;

  rram_cmd_seq #(
    .IO_W      (IO_W),
    .BLK_W     (BLK_W),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CE          (CE),
    .CLE         (CLE),
    .ALE         (ALE),
    .WE          (WE),
    .IO          (IO),
    .rram_data   (rram_data),
    .pulse_len   (pulse_len),
    .RB          (RB),
    .rram_ce     (rram_ce),
    .rram_we     (rram_we),
    .rram_re     (rram_re),
    .dout_block  (dout_block),
    .dout_row    (dout_row),
    .dout_column (dout_column),
    .op_pass     (op_pass),
    .op_fail     (op_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic       pass;
    logic       fail;
    int         we_n;
    int         re_n;
    int         pulses;
    logic [3:0] blk;
    logic [7:0] row;
    logic [7:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int tag, input logic pass, input logic fail, input int we_n,
                          input int re_n, input int pulses, input logic [3:0] blk,
                          input logic [7:0] row, input logic [7:0] col);
    exp_t e;
    e.tag = tag; e.pass = pass; e.fail = fail; e.we_n = we_n; e.re_n = re_n;
    e.pulses = pulses; e.blk = blk; e.row = row; e.col = col;
    exp_q.push_back(e);
  endtask

  // Monitor: gathers activity while busy and scores each completion.
  initial begin : monitor
    int   we_n;
    int   re_n;
    int   pulses;
    logic prev_rb;
    logic prev_we;
    exp_t e;
    we_n = 0; re_n = 0; pulses = 0; prev_rb = 1'b1; prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_n = 0; re_n = 0; pulses = 0; prev_rb = 1'b1; prev_we = 1'b0;
      end else begin
        if (!RB) begin
          if (rram_we) we_n++;
          if (rram_re) re_n++;
          if (rram_we && !prev_we) pulses++;
        end
        if (RB && !prev_rb) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_op: completion with empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("op%0d pass", e.tag), 32'(op_pass), 32'(e.pass));
            check($sformatf("op%0d fail", e.tag), 32'(op_fail), 32'(e.fail));
            check($sformatf("op%0d we_cycles", e.tag), we_n, e.we_n);
            check($sformatf("op%0d re_cycles", e.tag), re_n, e.re_n);
            check($sformatf("op%0d pulses", e.tag), pulses, e.pulses);
            check($sformatf("op%0d block", e.tag), 32'(dout_block), 32'(e.blk));
            check($sformatf("op%0d row", e.tag), 32'(dout_row), 32'(e.row));
            check($sformatf("op%0d column", e.tag), 32'(dout_column), 32'(e.col));
          end
          we_n = 0; re_n = 0; pulses = 0;
        end
        prev_rb = RB;
        prev_we = rram_we;
      end
    end
  end

  task automatic strobe(input logic cle, input logic ale, input logic [3:0] val,
                        input logic ce);
    @(posedge clk);
    #1;
    CE = ce; CLE = cle; ALE = ale; IO = val; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0; CLE = 1'b0; ALE = 1'b0; CE = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!RB && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({"ready_", name}, 32'(RB), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    repeat (4) @(negedge clk);
    check(name, 32'(RB), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Hold a would-be FORM strobe through reset.
    rst = 1'b1; CE = 1'b0; CLE = 1'b1; IO = C_FORM; WE = 1'b1;
    repeat (3) @(negedge clk);
    check("rst RB", 32'(RB), 32'd1);
    check("rst rram_ce", 32'(rram_ce), 32'd0);
    check("rst rram_we", 32'(rram_we), 32'd0);
    check("rst rram_re", 32'(rram_re), 32'd0);
    check("rst block", 32'(dout_block), 32'd0);
    check("rst row", 32'(dout_row), 32'd0);
    check("rst column", 32'(dout_column), 32'd0);
    check("rst op_pass", 32'(op_pass), 32'd0);
    check("rst op_fail", 32'(op_fail), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 WE = 1'b0; CLE = 1'b0;
    // Had FORM been latched on the release edge, this confirm would start an op.
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    check_idle("no_strobe_on_release");

    // Op 1: FORM, pulse_len 3, cell reads back 1.
    pulse_len = 8'd3; rram_data = 1'b1;
    push_exp(1, 1'b1, 1'b0, 3, VER, 1, 4'h0, 8'h00, 8'h00);
    strobe(1'b1, 1'b0, C_FORM, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    @(negedge clk);
    check("op1 RB_low_after_confirm", 32'(RB), 32'd0);
    check("op1 rram_ce_after_confirm", 32'(rram_ce), 32'd1);
    wait_ready("op1");

    // Op 2: SET with address 3,A,5,C,7 and pulse_len 0 (one-cycle pulse).
    pulse_len = 8'd0;
    push_exp(2, 1'b1, 1'b0, 1, VER, 1, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_SET, 1'b0);
    strobe(1'b0, 1'b1, 4'h3, 1'b0);
    strobe(1'b0, 1'b1, 4'hA, 1'b0);
    strobe(1'b0, 1'b1, 4'h5, 1'b0);
    strobe(1'b0, 1'b1, 4'hC, 1'b0);
    strobe(1'b0, 1'b1, 4'h7, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    wait_ready("op2");

    // Ops 3/4: READ senses directly; address persists.
    rram_data = 1'b0;
    push_exp(3, 1'b0, 1'b0, 0, 1, 0, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_READ, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    wait_ready("op3");
    rram_data = 1'b1;
    push_exp(4, 1'b1, 1'b0, 0, 1, 0, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_READ, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    wait_ready("op4");

    // Ignored sequences: bad opcode in idle, non-confirm in CMD, CE high.
    strobe(1'b1, 1'b0, 4'hF, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    check_idle("bad_opcode_ignored");
    strobe(1'b1, 1'b0, C_FORM, 1'b0);
    strobe(1'b1, 1'b0, 4'h3, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    check_idle("cmd_other_opcode_to_idle");
    strobe(1'b1, 1'b0, C_FORM, 1'b1);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    check_idle("ce_high_strobe_ignored");
    check("sticky_op_pass", 32'(op_pass), 32'd1);

    // Op 5: CE raised mid-PULSE after two pulse cycles.
    pulse_len = 8'd5;
    push_exp(5, 1'b0, 1'b1, 2, 0, 1, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_FORM, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    @(posedge clk);
    #1 CE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort rram_we", 32'(rram_we), 32'd0);
    check("abort rram_ce", 32'(rram_ce), 32'd0);
    check("abort RB", 32'(RB), 32'd1);
    check("abort op_fail", 32'(op_fail), 32'd1);
    CE = 1'b0;
    repeat (8) @(negedge clk);

`ifdef RRAM_VERIFY_EN
    // Op 6: RESET never verifies (cell stays 1): 1 + MAX_RETRY pulses, fail.
    pulse_len = 8'd2; rram_data = 1'b1;
    push_exp(6, 1'b0, 1'b1, 6, 3, 3, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_RESET, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    wait_ready("op6");

    // Op 7: FORM fails first verify, passes second.
    rram_data = 1'b0;
    push_exp(7, 1'b1, 1'b0, 4, 2, 2, 4'h3, 8'hA5, 8'hC7);
    strobe(1'b1, 1'b0, C_FORM, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    n = 0;
    while (!rram_re && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("op7 first_verify_seen", 32'(rram_re), 32'd1);
    @(posedge clk);
    #1 rram_data = 1'b1;
    wait_ready("op7");
`endif

    // Reset asserted while sensing: outputs return to reset values at once.
    strobe(1'b1, 1'b0, C_READ, 1'b0);
    strobe(1'b1, 1'b0, C_CONFIRM, 1'b0);
    check("pre_rst rram_re", 32'(rram_re), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst RB", 32'(RB), 32'd1);
    check("mid_rst rram_ce", 32'(rram_ce), 32'd0);
    check("mid_rst rram_re", 32'(rram_re), 32'd0);
    check("mid_rst rram_we", 32'(rram_we), 32'd0);
    check("mid_rst block", 32'(dout_block), 32'd0);
    check("mid_rst row", 32'(dout_row), 32'd0);
    check("mid_rst column", 32'(dout_column), 32'd0);
    check("mid_rst op_pass", 32'(op_pass), 32'd0);
    check("mid_rst op_fail", 32'(op_fail), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
